// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helper for the MixColumns stage.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_COL_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] GF_01 = 8'h01;
    localparam logic [7:0] GF_02 = 8'h02;
    localparam logic [7:0] GF_03 = 8'h03;
    localparam logic [7:0] GF_09 = 8'h09;
    localparam logic [7:0] GF_0B = 8'h0b;
    localparam logic [7:0] GF_0D = 8'h0d;
    localparam logic [7:0] GF_0E = 8'h0e;

    // Row 0 coefficients; row i uses this list rotated right by i.
    localparam logic [7:0] FWD_COEF [4] = '{GF_02, GF_03, GF_01, GF_01};
    localparam logic [7:0] INV_COEF [4] = '{GF_0E, GF_0B, GF_0D, GF_09};

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/gf_mult.sv
// GF(2^8) multiplier (poly 0x11B), shift-and-add form, purely combinational.
module gf_mult
    import aes_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);

    always_comb begin
        logic [7:0] w_sh;
        o_p  = '0;
        w_sh = i_a;
        for (int k = 0; k < 8; k++) begin
            if (i_b[k]) begin
                o_p = o_p ^ w_sh;
            end
            w_sh = xtime(w_sh);
        end
    end

endmodule

// File: rtl/mix_column_word.sv
// One-column MixColumns / InvMixColumns: 4x4 GF(2^8) matrix times a 4-byte column.
module mix_column_word
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] i_col,
    input  logic                 i_inv,
    output logic [AES_COL_W-1:0] o_col
);

    logic [7:0] w_a [4];
    logic [7:0] w_p [4][4];

    for (genvar j = 0; j < 4; j++) begin : g_split
        assign w_a[j] = i_col[31-8*j -: 8];
    end

    for (genvar i = 0; i < 4; i++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_col
            localparam int K = (j - i + 4) % 4;
            gf_mult u_mult (
                .i_a (w_a[j]),
                .i_b (i_inv ? INV_COEF[K] : FWD_COEF[K]),
                .o_p (w_p[i][j])
            );
        end
        assign o_col[31-8*i -: 8] = w_p[i][0] ^ w_p[i][1] ^ w_p[i][2] ^ w_p[i][3];
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative MixColumns stage: one column per cycle, valid/ready on both sides.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    state_t                 r_state;
    state_t                 w_next;
    logic [1:0]             r_col;
    logic [AES_STATE_W-1:0] r_data;
    logic                   r_inv;
    logic [AES_STATE_W-1:0] r_out;
    logic [AES_COL_W-1:0]   w_col_in;
    logic [AES_COL_W-1:0]   w_col_out;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)      w_next = ST_RUN;
            ST_RUN:  if (r_col == 2'd3) w_next = ST_DONE;
            ST_DONE: if (out_ready)     w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_col_in = r_data[127:96];
        case (r_col)
            2'd0: w_col_in = r_data[127:96];
            2'd1: w_col_in = r_data[95:64];
            2'd2: w_col_in = r_data[63:32];
            2'd3: w_col_in = r_data[31:0];
            default: w_col_in = r_data[127:96];
        endcase
    end

    mix_column_word u_word (
        .i_col (w_col_in),
        .i_inv (r_inv),
        .o_col (w_col_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_col   <= 2'd0;
            r_data  <= '0;
            r_inv   <= 1'b0;
            r_out   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data <= in_state;
                        r_inv  <= in_inv & INV_EN;
                        r_col  <= 2'd0;
                    end
                end
                ST_RUN: begin
                    // Counter wraps to 0 after column 3, ready for the next state.
                    r_col <= r_col + 2'd1;
                    case (r_col)
                        2'd0: r_out[127:96] <= w_col_out;
                        2'd1: r_out[95:64]  <= w_col_out;
                        2'd2: r_out[63:32]  <= w_col_out;
                        2'd3: r_out[31:0]   <= w_col_out;
                        default: r_out[127:96] <= w_col_out;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_state = r_out;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: vector table, backpressure, mid-run reset, INV_EN=0, random round trips.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_inv;
    logic         out_ready;
    logic [127:0] in_state;

    logic         in_ready,  out_valid,  busy;
    logic [127:0] out_state;
    logic [1:0]   dbg_state;
    logic         in_ready0, out_valid0, busy0;
    logic [127:0] out_state0;
    logic [1:0]   dbg_state0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q[$];

    localparam int FWD_M [16] = '{2, 3, 1, 1,  1, 2, 3, 1,  1, 1, 2, 3,  3, 1, 1, 2};
    localparam int INV_M [16] = '{14, 11, 13, 9,  9, 14, 11, 13,  13, 9, 14, 11,  11, 13, 9, 14};

    localparam logic [127:0] T1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] T1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] T3_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] T3_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    mix_columns_seq #(.INV_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    mix_columns_seq #(.INV_EN(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_state  (in_state),
        .in_inv    (in_inv),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_state (out_state0),
        .busy      (busy0),
        .dbg_state (dbg_state0)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain GF(2^8) arithmetic and matrix product per column
    function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
        int p  = 0;
        int aa = int'(a);
        int bb = b;
        while (bb != 0) begin
            if ((bb & 1) != 0) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
            bb = bb >> 1;
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
        logic [127:0] r = '0;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(s[127-32*c-8*j -: 8], inv ? INV_M[4*i+j] : FWD_M[4*i+j]);
                end
                r[127-32*c-8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Scoreboard compare
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Driver: present a state, wait for out_valid (bounded), leave block in DONE
    task automatic start_and_wait(input logic [127:0] s, input logic inv, output int lat);
        in_state = s;
        in_inv   = inv;
        in_valid = 1'b1;
        check("in_ready_before_accept", {127'b0, in_ready}, 128'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 128'(lat), 128'd4);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("out_valid_falls", {127'b0, out_valid}, 128'd0);
        check("in_ready_after_release", {127'b0, in_ready}, 128'd1);
    endtask

    task automatic run_op(input logic [127:0] s, input logic inv,
                          output logic [127:0] res, output logic [127:0] res0);
        int lat;
        start_and_wait(s, inv, lat);
        res  = out_state;
        res0 = out_state0;
        release_out();
    endtask

    typedef struct {
        logic [127:0] s;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [3];

    initial begin
        logic [127:0] res, res0, fwd, s;
        int lat;

        vecs[0] = '{s: T1_IN,  inv: 1'b0, exp: T1_OUT};
        vecs[1] = '{s: T1_OUT, inv: 1'b1, exp: T1_IN};
        vecs[2] = '{s: T3_IN,  inv: 1'b0, exp: T3_OUT};

        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_state = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_in_ready",  {127'b0, in_ready},  128'd1);
        check("reset_out_valid", {127'b0, out_valid}, 128'd0);
        check("reset_out_state", out_state, 128'd0);
        check("reset_busy",      {127'b0, busy},      128'd0);
        check("reset_out_state_inv_en0", out_state0, 128'd0);

        // Known-answer table
        for (int i = 0; i < 3; i++) begin
            run_op(vecs[i].s, vecs[i].inv, res, res0);
            check($sformatf("vector_%0d", i), res, vecs[i].exp);
            check($sformatf("vector_%0d_inv_en0", i), res0, mix_model(vecs[i].s, 1'b0));
        end

        // Backpressure in DONE with ignored in_valid pulses
        start_and_wait(T3_IN, 1'b0, lat);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            check("bp_out_valid", {127'b0, out_valid}, 128'd1);
            check("bp_out_state", out_state, T3_OUT);
            check("bp_in_ready",  {127'b0, in_ready},  128'd0);
        end
        in_valid = 1'b0;
        release_out();
        check("idle_retains_out_state", out_state, T3_OUT);
        check("idle_busy", {127'b0, busy}, 128'd0);

        // Reset while the third column is pending
        in_state = T1_IN; in_inv = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("busy_mid_run", {127'b0, busy}, 128'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready",  {127'b0, in_ready},  128'd1);
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_out_state", out_state, 128'd0);
        check("rst_busy",      {127'b0, busy},      128'd0);
        run_op(T1_IN, 1'b0, res, res0);
        check("after_reset_vector_1", res, T1_OUT);

        // in_inv ignored when INV_EN=0
        run_op(T1_IN, 1'b1, res, res0);
        check("inv_en0_forces_forward", res0, T1_OUT);
        check("inv_en1_inverse", res, mix_model(T1_IN, 1'b1));

        // Random back-to-back states, forward then inverse round trip
        for (int n = 0; n < 15; n++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(mix_model(s, 1'b0));
            run_op(s, 1'b0, fwd, res0);
            check("rand_forward", fwd, exp_q.pop_front());
            exp_q.push_back(s);
            run_op(fwd, 1'b1, res, res0);
            check("rand_round_trip", res, exp_q.pop_front());
            check("rand_inv_en0", res0, mix_model(fwd, 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
